// File: rtl/spi_bank_loader_if.sv
// rtl/spi_bank_loader_if.sv - SPI pins and bank write port of spi_bank_loader
interface spi_bank_loader_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic                  spi_sclk;
  logic                  spi_cs_n;
  logic                  spi_mosi;
  logic                  csen;
  logic                  wrenb;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH:0]   byte_cnt;
  logic                  err;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  csen, wrenb, addr_b, data_b, busy, done, byte_cnt, err
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output csen, wrenb, addr_b, data_b, busy, done, byte_cnt, err
  );
endinterface

// File: rtl/spi_bank_loader.sv
// rtl/spi_bank_loader.sv - SPI session loader writing bytes into a bank; LOADER_ADDR_WRAP_EN wraps the address at DATA_DEPTH
module spi_bank_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 1024
) (
  input logic              clk,
  input logic              rst_n,
  spi_bank_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH   = (ADDR_WIDTH+1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_MAX = '1;
`ifdef LOADER_ADDR_WRAP_EN
  localparam logic [ADDR_WIDTH:0] LAST    = DEPTH - ONE;
`endif

  state_t                state, state_nx;
  logic [1:0]            sclk_sync, cs_sync, mosi_sync;
  logic                  sclk_d, cs_d;
  logic                  sclk_rise, cs_fall, cs_rise;
  logic [14:0]           shreg;
  logic [15:0]           shreg_nx;
  logic [3:0]            bit_cnt;
  logic [7:0]            byte_q;
  logic                  byte_vld, byte_vld_d;
  logic                  blocked, err_q, wr_q, done_c, pending;
  logic [ADDR_WIDTH:0]   addr_cnt, cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  unused_hdr;

  assign sclk_rise  = sclk_sync[1] & ~sclk_d;
  assign cs_fall    = ~cs_sync[1] & cs_d;
  assign cs_rise    = cs_sync[1] & ~cs_d;
  assign shreg_nx   = {shreg, mosi_sync[1]};
  assign unused_hdr = ^shreg_nx;
  // A byte still in the write pipeline must land before done is reported
  assign pending    = byte_vld | byte_vld_d | wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    done_c   = 1'b0;
    unique case (state)
      IDLE: if (cs_fall) state_nx = HDR;
      HDR: begin
        if (cs_rise) state_nx = DONE;
        else if (sclk_rise && bit_cnt == 4'd15) state_nx = DATA;
      end
      DATA: if (cs_rise) state_nx = DONE;
      DONE: begin
        if (!pending) begin
          done_c   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync  <= '0;
      cs_sync    <= '0;
      mosi_sync  <= '0;
      sclk_d     <= 1'b0;
      cs_d       <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_q     <= '0;
      byte_vld   <= 1'b0;
      byte_vld_d <= 1'b0;
      blocked    <= 1'b0;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_cnt   <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[0], bus.spi_sclk};
      cs_sync    <= {cs_sync[0], bus.spi_cs_n};
      mosi_sync  <= {mosi_sync[0], bus.spi_mosi};
      sclk_d     <= sclk_sync[1];
      cs_d       <= cs_sync[1];
      byte_vld   <= 1'b0;
      byte_vld_d <= byte_vld;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;

      if (state == IDLE && cs_fall) begin
        err_q   <= 1'b0;
        cnt_q   <= '0;
        bit_cnt <= '0;
        shreg   <= '0;
        blocked <= 1'b0;
      end

      if (state == HDR) begin
        if (sclk_rise) begin
          shreg   <= shreg_nx[14:0];
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            addr_cnt <= {1'b0, shreg_nx[ADDR_WIDTH-1:0]};
            if ({1'b0, shreg_nx[ADDR_WIDTH-1:0]} >= DEPTH) begin
              err_q   <= 1'b1;
              blocked <= 1'b1;
            end
          end
        end
        if (cs_rise && !(sclk_rise && bit_cnt == 4'd15)) err_q <= 1'b1;
      end

      if (state == DATA && sclk_rise) begin
        shreg <= shreg_nx[14:0];
        if (bit_cnt == 4'd7) begin
          byte_q   <= shreg_nx[7:0];
          byte_vld <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end

      // Write stage sits two cycles behind byte completion to hold the fixed sclk-to-wrenb latency
      if (byte_vld_d && !blocked) begin
        if (addr_cnt < DEPTH) begin
          wr_q   <= 1'b1;
          addr_q <= addr_cnt[ADDR_WIDTH-1:0];
          data_q <= DATA_WIDTH'(byte_q);
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + ONE;
`ifdef LOADER_ADDR_WRAP_EN
          addr_cnt <= (addr_cnt == LAST) ? '0 : addr_cnt + ONE;
`else
          addr_cnt <= addr_cnt + ONE;
`endif
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.csen     = wr_q;
  assign bus.wrenb    = wr_q;
  assign bus.addr_b   = addr_q;
  assign bus.data_b   = data_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_c;
  assign bus.byte_cnt = cnt_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_spi_bank_loader.sv
// tb/tb_spi_bank_loader.sv - directed self-checking bench for spi_bank_loader
module tb_spi_bank_loader;
  localparam int AW = 13;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   d0;
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  time  wr_t = 0;
  time  done_t = 0;

  spi_bank_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spi_bank_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(1024)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wrenb) begin
      wa.push_back(bus.addr_b);
      wd.push_back(bus.data_b);
      wr_t = $time;
      chk("csen_with_wrenb", 32'(bus.csen), 32'd1);
    end else begin
      chk("bank_idle_zero", {29'd0, bus.csen, |bus.addr_b, |bus.data_b}, 32'd0);
    end
    if (bus.done) begin
      done_cnt++;
      done_t = $time;
    end
  end

  task automatic chk_wr(input string tag, input int idx, input int a, input int d);
    if (wa.size() > idx) begin
      chk({tag, "_addr"}, 32'(wa[idx]), 32'(a));
      chk({tag, "_data"}, 32'(wd[idx]), 32'(d));
    end else begin
      chk({tag, "_present"}, 32'(wa.size()), 32'(idx + 1));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_csen"},  32'(bus.csen), 32'd0);
    chk({tag, "_wrenb"}, 32'(bus.wrenb), 32'd0);
    chk({tag, "_addr"},  32'(bus.addr_b), 32'd0);
    chk({tag, "_data"},  32'(bus.data_b), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_cnt"},   32'(bus.byte_cnt), 32'd0);
    chk({tag, "_err"},   32'(bus.err), 32'd0);
  endtask

  // mode 0: plain; mode 1: probe wrenb latency on the last bit; mode 2: raise cs_n with the last sclk rise
  task automatic spi_word(input logic [15:0] v, input int n, input int mode);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      bus.spi_mosi = v[i];
      repeat (8) @(negedge clk);
      bus.spi_sclk = 1'b1;
      if (i == 0 && mode == 2) bus.spi_cs_n = 1'b1;
      if (i == 0 && mode == 1) begin
        repeat (4) @(negedge clk);
        chk("lat_before", 32'(bus.wrenb), 32'd0);
        @(negedge clk);
        chk("lat_wrenb", 32'(bus.wrenb), 32'd1);
        chk("lat_addr", 32'(bus.addr_b), 32'd16);
        chk("lat_data", 32'(bus.data_b), 32'hA5);
        repeat (3) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (8) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic new_session();
    wa.delete();
    wd.delete();
    d0 = done_cnt;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Basic two-byte load with wrenb latency probe
    new_session();
    cs_low();
    chk("s1_busy", 32'(bus.busy), 32'd1);
    spi_word(16'h0010, 16, 0);
    spi_word(16'h00A5, 8, 1);
    spi_word(16'h003C, 8, 0);
    cs_high();
    chk("s1_nwr", 32'(wa.size()), 32'd2);
    chk_wr("s1_w0", 0, 16, 'hA5);
    chk_wr("s1_w1", 1, 17, 'h3C);
    chk("s1_done", 32'(done_cnt - d0), 32'd1);
    chk("s1_cnt", 32'(bus.byte_cnt), 32'd2);
    chk("s1_err", 32'(bus.err), 32'd0);
    chk("s1_busy_end", 32'(bus.busy), 32'd0);

    // Last address then one past it
    new_session();
    cs_low();
    spi_word(16'h03FF, 16, 0);
    spi_word(16'h0011, 8, 0);
    spi_word(16'h0022, 8, 0);
    cs_high();
    chk_wr("s2_w0", 0, 1023, 'h11);
`ifdef LOADER_ADDR_WRAP_EN
    chk("s2_nwr", 32'(wa.size()), 32'd2);
    chk_wr("s2_w1", 1, 0, 'h22);
    chk("s2_cnt", 32'(bus.byte_cnt), 32'd2);
    chk("s2_err", 32'(bus.err), 32'd0);
`else
    chk("s2_nwr", 32'(wa.size()), 32'd1);
    chk("s2_cnt", 32'(bus.byte_cnt), 32'd1);
    chk("s2_err", 32'(bus.err), 32'd1);
`endif
    chk("s2_done", 32'(done_cnt - d0), 32'd1);

    // Start address out of range
    new_session();
    cs_low();
    spi_word(16'h0400, 16, 0);
    spi_word(16'h0055, 8, 0);
    cs_high();
    chk("s3_nwr", 32'(wa.size()), 32'd0);
    chk("s3_err", 32'(bus.err), 32'd1);
    chk("s3_cnt", 32'(bus.byte_cnt), 32'd0);
    chk("s3_done", 32'(done_cnt - d0), 32'd1);

    // Trailing partial byte is discarded
    new_session();
    cs_low();
    spi_word(16'h0000, 16, 0);
    spi_word(16'h00C3, 8, 0);
    spi_word(16'h0015, 5, 0);
    cs_high();
    chk("s4_nwr", 32'(wa.size()), 32'd1);
    chk_wr("s4_w0", 0, 0, 'hC3);
    chk("s4_cnt", 32'(bus.byte_cnt), 32'd1);
    chk("s4_err", 32'(bus.err), 32'd0);

    // Reset mid-header, then cs_n already low must not start a session
    new_session();
    cs_low();
    spi_word(16'h0123, 12, 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("s5_rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    spi_word(16'h0005, 16, 0);
    spi_word(16'h0066, 8, 0);
    repeat (10) @(negedge clk);
    chk("s5_busy_stale_cs", 32'(bus.busy), 32'd0);
    cs_high();
    chk("s5_nwr_stale", 32'(wa.size()), 32'd0);
    chk("s5_done_stale", 32'(done_cnt - d0), 32'd0);
    cs_low();
    spi_word(16'h0002, 16, 0);
    spi_word(16'h007E, 8, 0);
    cs_high();
    chk("s5_nwr", 32'(wa.size()), 32'd1);
    chk_wr("s5_w0", 0, 2, 'h7E);
    chk("s5_done", 32'(done_cnt - d0), 32'd1);

    // Back-to-back sessions with a two sclk-period gap
    new_session();
    cs_low();
    spi_word(16'h03FE, 16, 0);
    spi_word(16'h0001, 8, 0);
    spi_word(16'h0002, 8, 0);
    spi_word(16'h0003, 8, 0);
    cs_high();
`ifdef LOADER_ADDR_WRAP_EN
    chk("s6a_cnt", 32'(bus.byte_cnt), 32'd3);
    chk("s6a_err", 32'(bus.err), 32'd0);
`else
    chk("s6a_cnt", 32'(bus.byte_cnt), 32'd2);
    chk("s6a_err", 32'(bus.err), 32'd1);
`endif
    chk_wr("s6a_w1", 1, 1023, 'h02);
    repeat (11) @(negedge clk);
    cs_low();
    chk("s6b_err_clr", 32'(bus.err), 32'd0);
    chk("s6b_cnt_clr", 32'(bus.byte_cnt), 32'd0);
    chk("s6b_busy", 32'(bus.busy), 32'd1);
    wa.delete();
    wd.delete();
    spi_word(16'h0020, 16, 0);
    spi_word(16'h0044, 8, 0);
    cs_high();
    chk("s6b_nwr", 32'(wa.size()), 32'd1);
    chk_wr("s6b_w0", 0, 32, 'h44);
    chk("s6_two_done", 32'(done_cnt - d0), 32'd2);

    // cs_n rises together with the last sclk edge of a byte
    new_session();
    cs_low();
    spi_word(16'h0007, 16, 0);
    spi_word(16'h0099, 8, 2);
    repeat (20) @(negedge clk);
    chk("s7_nwr", 32'(wa.size()), 32'd1);
    chk_wr("s7_w0", 0, 7, 'h99);
    chk("s7_done", 32'(done_cnt - d0), 32'd1);
    chk("s7_order", 32'(done_t > wr_t), 32'd1);
    chk("s7_cnt", 32'(bus.byte_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_bank_loader.md
SPI_BANK_LOADER -- requirements
Module: spi_bank_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 13: width of the bank write address.
REQ-002 Parameter DATA_WIDTH, default 8: width of the bank write data; SPI bytes are 8 bits.
REQ-003 Parameter DATA_DEPTH, default 1024: number of words in the target bank.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and rst_n.
REQ-005 clk  input  1  system clock; also samples the SPI pins.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 spi_sclk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-008 spi_cs_n  input  1  SPI chip select, active low; frames one session.
REQ-009 spi_mosi  input  1  SPI data, MSB first.
REQ-010 csen  output  1  bank chip enable.
REQ-011 wrenb  output  1  bank write strobe.
REQ-012 addr_b  output  ADDR_WIDTH  bank write address.
REQ-013 data_b  output  DATA_WIDTH  bank write data, zero-extended from the received byte.
REQ-014 busy  output  1  a session is in progress.
REQ-015 done  output  1  one-cycle pulse when a session ends.
REQ-016 byte_cnt  output  ADDR_WIDTH+1  number of data bytes written in the current or last session.
REQ-017 err  output  1  sticky error flag, cleared at the start of the next session.

Function
REQ-018 spi_sclk, spi_cs_n and spi_mosi SHALL each pass through a 2-flop synchronizer; the sclk rising edge SHALL be detected on the synchronized signal.
REQ-019 The block SHALL support f_clk >= 8 x f_sclk.
REQ-020 The state machine SHALL have the states IDLE, HDR, DATA and DONE.
REQ-021 IDLE -> HDR on synchronized cs_n falling; on this transition err and byte_cnt SHALL clear and busy SHALL assert.
REQ-022 HDR SHALL shift in 16 bits; the low ADDR_WIDTH bits load the address counter and the upper bits are ignored; HDR -> DATA after bit 16.
REQ-023 If the start address is >= DATA_DEPTH, err SHALL set and no writes SHALL occur in that session.
REQ-024 In DATA, each completed 8-bit byte SHALL produce exactly one clk cycle with csen=1, wrenb=1, addr_b=address counter and data_b=byte.
REQ-025 After each write, the address counter SHALL increment by 1 and byte_cnt SHALL increment by 1, saturating at 2^(ADDR_WIDTH+1)-1.
REQ-026 wrenb SHALL go high exactly 4 clk cycles after the first clk edge that samples spi_sclk high for bit 8 of the byte.
REQ-027 Outside write pulses, csen, wrenb, addr_b and data_b SHALL be 0.
REQ-028 On synchronized cs_n rising in any state other than IDLE, the block SHALL enter DONE, assert done for 1 cycle, then go to IDLE and deassert busy.
REQ-029 A partial byte or partial header at cs_n rise SHALL be discarded without a write; a partial header SHALL set err.
REQ-030 If cs_n rises in the same cycle a byte completes, the write SHALL still be issued before done is asserted.

Reset
REQ-031 While rst_n=0, all outputs, the synchronizers, the shift register and the counters SHALL be 0, and the state SHALL be IDLE.
REQ-032 Reset asserted mid-session SHALL abort the session; after release, the block SHALL wait for a new cs_n fall, even if cs_n is already low.

Configuration
REQ-033 With LOADER_ADDR_WRAP_EN defined, the address counter SHALL wrap from DATA_DEPTH-1 to 0, and writing continues.
REQ-034 Without LOADER_ADDR_WRAP_EN, bytes past address DATA_DEPTH-1 SHALL be dropped (no wrenb, byte_cnt not incremented) and err SHALL set.

Verification
REQ-035 Header 0x0010, bytes 0xA5 0x3C -> writes (16,0xA5) and (17,0x3C); then done pulse, byte_cnt=2, err=0.
REQ-036 Header 0x03FF, bytes 0x11 0x22 -> write (1023,0x11); with the macro, write (0,0x22) and byte_cnt=2; without the macro, no second write, byte_cnt=1, err=1.
REQ-037 Header 0x0400 with DATA_DEPTH=1024, byte 0x55 -> no wrenb, err=1, done pulse.
REQ-038 Header 0x0000, 1 byte, then 5 bits, then cs_n high -> exactly 1 write, byte_cnt=1, err=0.
REQ-039 rst_n pulsed low after 12 header bits -> all outputs 0, no writes; a new session with header 0x0002 and byte 0x7E -> write (2,0x7E).
REQ-040 Back-to-back sessions separated by 2 sclk periods of cs_n high -> err and byte_cnt reset at the second cs_n fall, with 2 distinct done pulses.
